// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus per-bit stable-count filter for
// push buttons and slide switches. Each bit also produces one-clock
// rise/fall pulses and a sticky held flag that software clears via clr.
// The filter advances only on the sample strobe; the synchronizer runs
// every clock.
module btn_debounce #(
  parameter int WIDTH  = 21,
  parameter int STABLE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] held,
  output logic             changed
);

  localparam int CW = $clog2(STABLE + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_d;

  // Two-stage synchronizer for the asynchronous pad levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // A bit is accepted on the STABLE-th consecutive differing tick.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = tick && (s2[i] != dout[i]) && (cnt[i] == LAST);
    end
  end

  // accept implies s2 differs from dout, so s2 alone gives the direction.
  assign rise_d = accept & s2;
  assign fall_d = accept & ~s2;

  // Per-bit run counters; any matching sample restarts the run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == dout[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Registered outputs; held set takes priority over clr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout    <= '0;
      rise    <= '0;
      fall    <= '0;
      held    <= '0;
      changed <= 1'b0;
    end else begin
      dout    <= dout ^ accept;
      rise    <= rise_d;
      fall    <= fall_d;
      held    <= rise_d | (held & ~clr);
      changed <= |(rise_d | fall_d);
    end
  end

endmodule
